// File: rtl/l2_cacheline_adaptor_pkg.sv
// Shared types and sizing for the L2 cacheline adaptor: FSM states, default
// line/beat widths and the byte-offset width used for line alignment.
package l2_pkg;

    localparam int unsigned LINE_W_DEF  = 256;
    localparam int unsigned BURST_W_DEF = 64;
    localparam int unsigned OFFSET_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/l2_cacheline_adaptor_if.sv
// Signal bundle between the L2 cache, the adaptor and burst memory.
// The adaptor takes the slave view; the L2/memory side takes the master view.
interface l2_cacheline_adaptor_if
    import l2_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
);
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Converts whole-line L2 fill/write-back requests into BEATS memory bursts,
// sharing one line buffer for fill capture and write-back drive.
module l2_cacheline_adaptor
    import l2_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
)
(
    input  logic                  clk,
    input  logic                  rst,
    l2_cacheline_adaptor_if.slave bus
);
    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_buf;
    logic [LINE_W-1:0]  fill_nxt;
    logic [LINE_W-1:0]  line_q;
    logic [31:0]        addr_q;
    logic [BURST_W-1:0] beat_sel;
    logic               last_beat;

    always_comb begin
        beat_sel = '0;
        fill_nxt = line_buf;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt == CNT_W'(b)) begin
                beat_sel                        = line_buf[b*BURST_W +: BURST_W];
                fill_nxt[b*BURST_W +: BURST_W]  = bus.burst_i;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.read_o  = 1'b0;
        bus.write_o = 1'b0;
        bus.resp_o  = 1'b0;
        bus.burst_o = '0;
        last_beat   = bus.resp_i && (cnt == LAST);
        case (state)
            IDLE: begin
                if (bus.write_i)     state_nxt = WRITE;
                else if (bus.read_i) state_nxt = READ;
            end
            READ: begin
                bus.read_o = 1'b1;
                if (last_beat) state_nxt = DONE;
            end
            WRITE: begin
                bus.write_o = 1'b1;
                bus.burst_o = beat_sel;
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                bus.resp_o = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // line_q is loaded only on the final fill beat so a write-back reusing
    // line_buf never disturbs the fill line presented to the L2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            line_buf <= '0;
            line_q   <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_i || bus.read_i) begin
                        addr_q <= {bus.address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        cnt    <= '0;
                        if (bus.write_i) line_buf <= bus.line_i;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        line_buf <= fill_nxt;
                        cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
                        if (cnt == LAST) line_q <= fill_nxt;
                    end
                end
                WRITE: begin
                    if (bus.resp_i) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.line_o    = line_q;
    assign bus.address_o = addr_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Scoreboard bench for l2_cacheline_adaptor: directed transactions push expected
// completions/beats; a negedge monitor pops and compares as the DUT responds.
module tb_l2_cacheline_adaptor;

    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [255:0] line;
    } cmp_t;

    logic clk;
    logic rst;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned ntx    = 0;
    int unsigned nresp  = 0;

    cmp_t        cq[$];
    logic [63:0] wq[$];

    l2_cacheline_adaptor_if #(.LINE_W(256), .BURST_W(64)) bus ();

    l2_cacheline_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction: request, then a resp_i pattern (bit i = cycle i) with
    // exactly four accepted beats, then one cycle for DONE->IDLE.
    task automatic run_txn(input logic is_write, input logic also_read,
                           input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] ln, input logic [15:0] pat,
                           input int unsigned plen);
        cmp_t e;
        int unsigned k;
        e.is_read = !is_write;
        e.addr    = exp_addr;
        e.line    = ln;
        cq.push_back(e);
        ntx++;
        if (is_write)
            for (int b = 0; b < 4; b++) wq.push_back(ln[b*64 +: 64]);
        bus.address_i = addr;
        bus.read_i    = !is_write || also_read;
        bus.write_i   = is_write;
        if (is_write) bus.line_i = ln;
        @(posedge clk); #1;
        if (also_read) begin
            chk("prio_write_o", 256'(bus.write_o), 256'(1'b1));
            chk("prio_read_o",  256'(bus.read_o),  256'(1'b0));
        end
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.address_i = 32'hFFFF_FFFF;
        bus.line_i    = ~ln;
        k = 0;
        for (int i = 0; i < int'(plen); i++) begin
            bus.resp_i  = pat[i];
            bus.burst_i = pat[i] ? ln[k*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (pat[i]) k++;
            @(posedge clk); #1;
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        @(posedge clk); #1;
    endtask

    // Monitor: scoreboard pops, write-beat checks, protocol invariants.
    initial begin
        int unsigned mk;
        logic prev_last, prev_resp, acc;
        cmp_t e;
        mk = 0; prev_last = 1'b0; prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mk = 0; prev_last = 1'b0; prev_resp = 1'b0;
            end else begin
                chk("rw_excl", 256'(bus.read_o & bus.write_o), 256'(1'b0));
                if (prev_resp) chk("resp_len", 256'(bus.resp_o), 256'(1'b0));
                if (bus.resp_o || prev_last) chk("resp_lat", 256'(bus.resp_o), 256'(prev_last));
                if (bus.resp_o) begin
                    nresp++;
                    chk("resp_expected", 256'(cq.size() != 0), 256'(1'b1));
                    chk("done_bus_idle", 256'({bus.read_o, bus.write_o}), 256'(2'b00));
                    if (cq.size() != 0) begin
                        e = cq.pop_front();
                        chk("address_o", 256'(bus.address_o), 256'(e.addr));
                        if (e.is_read) chk("line_o", bus.line_o, e.line);
                    end
                end
                if (bus.write_o) begin
                    chk("wbeat_expected", 256'(wq.size() != 0), 256'(1'b1));
                    if (wq.size() != 0) begin
                        chk("burst_o", 256'(bus.burst_o), 256'(wq[0]));
                        if (bus.resp_i) void'(wq.pop_front());
                    end
                end
                acc       = (bus.read_o | bus.write_o) & bus.resp_i;
                prev_last = acc && (mk == 3);
                if (acc) mk = (mk + 1) % 4;
                prev_resp = bus.resp_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l1, w1, l2, w2, l5, l3, l4;
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        w1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        l2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_0F0F_0F0F, 64'hA5A5_A5A5_A5A5_A5A5};
        w2 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
              64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        l5 = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
              64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};
        l3 = {64'h3000_0000_0000_0004, 64'h3000_0000_0000_0003,
              64'h3000_0000_0000_0002, 64'h3000_0000_0000_0001};
        l4 = {64'h4000_0000_0000_0008, 64'h4000_0000_0000_0007,
              64'h4000_0000_0000_0006, 64'h4000_0000_0000_0005};

        bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_read_o",    256'(bus.read_o),    256'(1'b0));
        chk("rst_write_o",   256'(bus.write_o),   256'(1'b0));
        chk("rst_resp_o",    256'(bus.resp_o),    256'(1'b0));
        chk("rst_address_o", 256'(bus.address_o), 256'(32'h0));
        chk("rst_line_o",    bus.line_o,          256'(0));
        @(posedge clk); #1 rst = 1'b1;

        run_txn(1'b0, 1'b0, 32'h0000_1234, 32'h0000_1220, l1, 16'h000F, 4);
        run_txn(1'b1, 1'b0, 32'h0000_5678, 32'h0000_5660, w1, 16'h002D, 6);
        run_txn(1'b0, 1'b0, 32'hABCD_EF7F, 32'hABCD_EF60, l2, 16'h0066, 7);
        run_txn(1'b1, 1'b1, 32'h8000_001F, 32'h8000_0000, w2, 16'h000F, 4);

        // Aborted read: two beats, then asynchronous reset mid-cycle.
        bus.address_i = 32'h0000_0900; bus.read_i = 1'b1;
        @(posedge clk); #1;
        bus.read_i = 1'b0; bus.resp_i = 1'b1; bus.burst_i = 64'h9999_0000_9999_0000;
        @(posedge clk); #1;
        bus.burst_i = 64'h9999_1111_9999_1111;
        @(posedge clk); #1;
        bus.resp_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_read_o",    256'(bus.read_o),    256'(1'b0));
        chk("abort_write_o",   256'(bus.write_o),   256'(1'b0));
        chk("abort_resp_o",    256'(bus.resp_o),    256'(1'b0));
        chk("abort_address_o", 256'(bus.address_o), 256'(32'h0));
        chk("abort_line_o",    bus.line_o,          256'(0));
        chk("abort_burst_o",   256'(bus.burst_o),   256'(64'h0));
        @(negedge clk); @(posedge clk); #1 rst = 1'b1;

        run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0000_0040, l5, 16'h000F, 4);

        // Back-to-back: request held through resp_o.
        begin
            cmp_t e;
            e.is_read = 1'b1; e.addr = 32'h0000_2000; e.line = l3; cq.push_back(e);
            e.is_read = 1'b1; e.addr = 32'h0000_3FE0; e.line = l4; cq.push_back(e);
            ntx += 2;
            bus.address_i = 32'h0000_2000; bus.read_i = 1'b1;
            @(posedge clk); #1;
            bus.address_i = 32'h0000_3FFF;
            for (int i = 0; i < 4; i++) begin
                bus.resp_i = 1'b1; bus.burst_i = l3[i*64 +: 64];
                @(posedge clk); #1;
            end
            bus.resp_i = 1'b0;
            @(posedge clk); #1;
            chk("b2b_gap_read_o", 256'(bus.read_o), 256'(1'b0));
            @(posedge clk); #1;
            chk("b2b_restart_read_o", 256'(bus.read_o), 256'(1'b1));
            bus.read_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bus.resp_i = 1'b1; bus.burst_i = l4[i*64 +: 64];
                @(posedge clk); #1;
            end
            bus.resp_i = 1'b0;
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("cq_drained", 256'(cq.size()), 256'(0));
        chk("wq_drained", 256'(wq.size()), 256'(0));
        chk("resp_count", 256'(nresp),     256'(ntx));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_cacheline_adaptor.md
L2_CACHELINE_ADAPTOR -- requirements
Module: l2_cacheline_adaptor

Interface
REQ-001 Parameter LINE_W, default 256, is the cacheline width in bits.
REQ-002 Parameter BURST_W, default 64, is the memory beat width; BEATS = LINE_W/BURST_W, which is 4 at the defaults.
REQ-003 Ports: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 line_i  in  LINE_W  write-back cacheline from the L2 cache.
REQ-007 line_o  out  LINE_W  fill cacheline to the L2 cache.
REQ-008 address_i  in  32  byte address from the L2 cache.
REQ-009 read_i  in  1  L2 fill request (mem_read).
REQ-010 write_i  in  1  L2 write-back request (mem_write).
REQ-011 resp_o  out  1  completion pulse to the L2 cache (mem_resp).
REQ-012 burst_i  in  BURST_W  read beat from memory.
REQ-013 burst_o  out  BURST_W  write beat to memory.
REQ-014 address_o  out  32  line-aligned memory address.
REQ-015 read_o  out  1  memory read request.
REQ-016 write_o  out  1  memory write request.
REQ-017 resp_i  in  1  memory beat-valid / beat-accept strobe.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE and DONE.
- IDLE->WRITE on write_i=1.
- IDLE->READ on read_i=1 and write_i=0; write has priority when both are high.
REQ-019 On leaving IDLE, address_o SHALL latch {address_i[31:5], 5'b0}, line_i SHALL latch into the line buffer for a write, and the beat counter SHALL clear to 0.
REQ-020 In READ, read_o SHALL be 1 and write_o 0.
- Each cycle with resp_i=1 captures burst_i into line slice [64k+63:64k], where k is the beat counter, and increments k.
- Cycles with resp_i=0 are wait states: no capture, no increment.
REQ-021 In WRITE, write_o SHALL be 1 and burst_o SHALL equal line buffer slice k.
- Each cycle with resp_i=1 increments k.
REQ-022 The beat counter SHALL be 2 bits; accepting beat k=3 SHALL wrap it to 0 and move the FSM to DONE.
REQ-023 read_o and write_o SHALL drop in the cycle after the last beat, and SHALL never both be 1.
REQ-024 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- Latency: resp_o is asserted 1 cycle after the 4th accepted beat.
REQ-025 line_o SHALL hold the last completed fill from DONE onward, stable until the next read's first beat.
REQ-026 Requests in DONE SHALL be ignored; a request still held on return to IDLE starts a new transaction. The L2 deasserts its request on seeing resp_o.
REQ-027 address_i, line_i, read_i and write_i changes after transaction start SHALL have no effect until IDLE.
REQ-028 resp_i in IDLE or DONE SHALL be ignored.

Reset
REQ-029 rst=0 SHALL immediately, asynchronously and independent of clk force:
- state IDLE, beat counter 0;
- line buffer and line_o 0, address_o 0;
- read_o, write_o, resp_o 0; burst_o 0.
REQ-030 Reset mid-burst SHALL abort the transaction with no resp_o; after rst returns to 1, the first transaction starts cleanly at beat 0.

Structure
REQ-031 The shared package l2_pkg SHALL hold the state enum, LINE_W/BURST_W defaults and the line-offset width (5).
REQ-032 The block SHALL be a single module with no sub-module.
- The line buffer is shared between fill capture and write-back drive.

Verification
REQ-033 Read, zero wait: read_i=1, address_i=0x0000_1234; resp_i=1 for 4 cycles with beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle, one cycle after beat 4.
REQ-034 Write with gaps: write_i=1, line_i=0xDDDD_CCCC_BBBB_AAAA pattern; resp_i=1,0,1,1,0,1 -> burst_o steps through slices 0..3 only on resp_i=1, write_o drops after the 4th accept, single resp_o.
REQ-035 Read and write both asserted in IDLE -> WRITE taken, read_o stays 0.
REQ-036 rst=0 after 2 read beats -> all outputs 0 asynchronously, no resp_o; a following read completes with correct line_o.
REQ-037 Back-to-back: request held through resp_o -> exactly one gap cycle (IDLE), then a new transaction.
- Checkers: read_o&write_o never both 1; resp_o never longer than 1 cycle.
